// File: rtl/ps2_pkg.sv
// ps2_pkg: declarations shared by the PS/2 receive path (and the future
// host-to-device transmitter).
//   ps2_rx_state_t     : receiver FSM states IDLE, DATA, PARITY, STOP
//   PS2_DATA_BITS      : payload bits per frame
//   PS2_FRAME_BITS     : start + data + parity + stop
//   PS2_TIMEOUT_CYCLES : default inactivity watchdog limit in system clocks
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam int unsigned PS2_DATA_BITS      = 8;
    localparam int unsigned PS2_FRAME_BITS     = 11;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 5000;

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: multi-flop synchronizer for the raw PS/2 clock and data
// lines plus falling-edge detection on the synchronized clock.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ps2_clk    : raw PS/2 clock line (asynchronous)
//   ps2_data   : raw PS/2 data line (asynchronous)
//   clk_fall   : high for one cycle after a falling edge reaches the last sync flop
//   data_sync  : synchronized data line, aligned with clk_fall
module ps2_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    logic [STAGES-1:0] clk_sr;
    logic [STAGES-1:0] data_sr;
    logic              clk_prev;

    // All flops reset to the idle-high line level so that releasing reset
    // with the bus idle does not look like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[STAGES-2:0], ps2_clk};
            data_sr  <= {data_sr[STAGES-2:0], ps2_data};
            clk_prev <= clk_sr[STAGES-1];
        end
    end

    assign clk_fall  = clk_prev & ~clk_sr[STAGES-1];
    assign data_sync = data_sr[STAGES-1];

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver. Deserializes 11-bit
// frames (start, 8 data LSB first, parity, stop) sampled on PS/2 clock
// falling edges. Parity is passed on unchecked.
// Optional feature: define PS2_RX_TIMEOUT_EN to build an inactivity watchdog
// that aborts a partial frame after TIMEOUT_CYCLES clocks without an edge.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ps2_clk      : raw PS/2 clock line
//   ps2_data     : raw PS/2 data line
//   rx_data      : last good byte, held until the next good frame
//   rx_parity    : parity bit of the last good frame
//   rx_valid     : one-cycle strobe, rx_data/rx_parity updated
//   rx_frame_err : one-cycle strobe, stop bit sampled low
//   rx_timeout   : one-cycle strobe, watchdog abort (0 without the watchdog)
//   rx_busy      : high while a frame is in progress
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_parity,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = $clog2(PS2_DATA_BITS);

    ps2_rx_state_t                    state;
    logic [CNT_W-1:0]                 bit_cnt;
    logic [PS2_DATA_BITS-1:0]         shreg;
    logic                             par_hold;
    logic                             fall;
    logic                             bit_in;
    logic                             wd_hit;

    ps2_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (fall),
        .data_sync (bit_in)
    );

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (fall || state == IDLE || wd_hit) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_hit = (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_hold     <= 1'b0;
            rx_data      <= '0;
            rx_parity    <= 1'b0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_timeout   <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_timeout   <= 1'b0;
            // A sampled edge wins over a watchdog terminal count in the same cycle.
            if (fall) begin
                case (state)
                    IDLE: begin
                        // A high sample here is a glitch, not a start bit.
                        if (!bit_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            rx_busy <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {bit_in, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(PS2_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_hold <= bit_in;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (bit_in) begin
                            rx_data   <= shreg;
                            rx_parity <= par_hold;
                            rx_valid  <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end else if (wd_hit) begin
                state      <= IDLE;
                rx_busy    <= 1'b0;
                rx_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
`timescale 1ns/1ps
module tb_ps2_rx_frame;

    localparam int CLK_P = 1000;   // 1 MHz system clock
    localparam int HALF  = 40000;  // 12.5 kHz PS/2 clock half period
`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TMO = 100;
`else
    localparam int unsigned TMO = 5000;
`endif

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_TMO   = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       parity;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_parity;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_timeout;
    logic       rx_busy;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_bad    = 0;
    int         n_valid  = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_par  = 1'b0;

    ps2_rx_frame #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_data      (rx_data),
        .rx_parity    (rx_parity),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_timeout   (rx_timeout),
        .rx_busy      (rx_busy)
    );

    always #(CLK_P/2) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest expectation.
    int   mon_kind;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && (rx_valid || rx_frame_err || rx_timeout)) begin
            mon_kind = rx_valid ? K_VALID : (rx_frame_err ? K_FERR : K_TMO);
            check_eq("strobe_onehot", 32'(rx_valid) + 32'(rx_frame_err) + 32'(rx_timeout), 1);
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", 32'(mon_kind), 32'd99);
            end else begin
                mon_e = sb.pop_front();
                check_eq("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
                check_eq("rx_data", 32'(rx_data), 32'(mon_e.data));
                check_eq("rx_parity", 32'(rx_parity), 32'(mon_e.parity));
            end
            if (rx_valid) n_valid++;
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        #(HALF);
        ps2_clk = 1'b0;
        #(HALF);
        ps2_clk = 1'b1;
    endtask

    // Last bit of an event: measure system clocks from pin capture to strobe.
    task automatic send_bit_timed(input logic b, input int limit, output int n);
        ps2_data = b;
        #(HALF);
        ps2_clk = 1'b0;
        n = 0;
        while (n < limit && !(rx_valid || rx_frame_err || rx_timeout)) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        #100;
        if (n * CLK_P < HALF) #(HALF - n * CLK_P);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic par;
        int   n;
        exp_t e;
        par = ~^d;
        if (stop_bit) begin
            e = '{K_VALID, d, par};
            last_data = d;
            last_par  = par;
        end else begin
            e = '{K_FERR, last_data, last_par};
        end
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit_timed(stop_bit, 20, n);
        check_eq("strobe_latency", 32'(n), 32'd3);
    endtask

    initial begin
        #(50_000_000);
        $display("FAIL global_timeout: got=hang exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   n;
        int   v0;
        logic busy_seen;
        logic [7:0] pd;

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        #100;
        check_eq("rst_rx_data", 32'(rx_data), 0);
        check_eq("rst_rx_parity", 32'(rx_parity), 0);
        check_eq("rst_strobes", 32'({rx_valid, rx_frame_err, rx_timeout}), 0);
        check_eq("rst_busy", 32'(rx_busy), 0);
        rst_n = 1'b1;
        #(HALF);

        // Basic frame
        send_frame(8'h1C, 1'b1);
        #(HALF);

        // Good frame then stop-bit error; rx_data/rx_parity must hold 0xE0
        send_frame(8'hE0, 1'b1);
        #(HALF);
        send_frame(8'h75, 1'b0);
        check_eq("ferr_hold_data", 32'(rx_data), 32'hE0);
        #(HALF);

        // Idle glitch: falling edge with data high
        busy_seen = 1'b0;
        ps2_data = 1'b1;
        #(HALF);
        ps2_clk = 1'b0;
        repeat (10) begin
            @(negedge clk);
            busy_seen = busy_seen | rx_busy;
        end
        #100;
        #(HALF - 10 * CLK_P);
        ps2_clk = 1'b1;
        #(HALF);
        check_eq("glitch_busy", 32'(busy_seen), 0);
        send_frame(8'h5A, 1'b1);
        #(HALF);

`ifdef PS2_RX_TIMEOUT_EN
        // Stall after the 5th falling edge: 3 clocks to reach the FSM plus
        // TMO clocks of inactivity before the abort strobe is visible.
        sb.push_back('{K_TMO, last_data, last_par});
        pd = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(pd[i]);
        send_bit_timed(pd[3], 300, n);
        check_eq("timeout_latency", 32'(n), 32'(TMO + 3));
        check_eq("timeout_busy", 32'(rx_busy), 0);
        check_eq("timeout_hold_data", 32'(rx_data), 32'(last_data));
        ps2_data = 1'b1;
        #(HALF);
        send_frame(8'hF0, 1'b1);
        #(HALF);
`endif

        // Reset in the middle of a frame
        pd = 8'h33;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(pd[i]);
        check_eq("midframe_busy", 32'(rx_busy), 1);
        #337;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rx_data", 32'(rx_data), 0);
        check_eq("arst_rx_parity", 32'(rx_parity), 0);
        check_eq("arst_strobes", 32'({rx_valid, rx_frame_err, rx_timeout}), 0);
        check_eq("arst_busy", 32'(rx_busy), 0);
        ps2_data  = 1'b1;
        last_data = 8'h00;
        last_par  = 1'b0;
        repeat (3) @(negedge clk);
        #100;
        rst_n = 1'b1;
        #(HALF);
        check_eq("release_busy", 32'(rx_busy), 0);
        send_frame(8'h12, 1'b1);

        // Back-to-back frames, stop bit followed directly by the next start bit
        v0 = n_valid;
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("b2b_valid_count", 32'(n_valid - v0), 2);
        check_eq("final_rx_data", 32'(rx_data), 32'h75);

        check_eq("scoreboard_empty", 32'(sb.size()), 0);
`ifdef PS2_RX_TIMEOUT_EN
        check_eq("total_valid", 32'(n_valid), 7);
`else
        check_eq("total_valid", 32'(n_valid), 6);
`endif
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

PS/2 device-to-host frame receiver. Oversamples the open-collector `ps2_clk`/`ps2_data` lines in the system clock domain and deserializes each 11-bit frame (start, 8 data LSB-first, parity, stop). It presents the data byte and the raw parity bit to the downstream `parity_check` stage. A frame-format error flag and an optional inactivity watchdog abort malformed or stalled frames.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on both PS/2 lines (≥2).
- `TIMEOUT_CYCLES`, 5000: system clocks without a PS/2 falling edge before a partial frame is aborted (used only with the watchdog compiled in).
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: asynchronous active-low reset.
- `ps2_clk` in 1: raw PS/2 clock line (asynchronous).
- `ps2_data` in 1: raw PS/2 data line (asynchronous).
- `rx_data` out 8: last good byte. Holds until the next good frame.
- `rx_parity` out 1: parity bit of the last good frame, unchecked. Goes to `parity_check.parity`.
- `rx_valid` out 1: one-cycle strobe. `rx_data`/`rx_parity` updated this cycle.
- `rx_frame_err` out 1: one-cycle strobe. Stop bit sampled 0.
- `rx_timeout` out 1: one-cycle strobe. Watchdog abort.
- `rx_busy` out 1: high while state ≠ IDLE.

## Operation
- Both lines pass through `SYNC_STAGES` flops. Sync flops and the edge-detect history flop reset to 1 (idle-high), so reset release causes no false edge.
- `fall` = previous synchronized clk AND NOT current synchronized clk. `ps2_data` is sampled from its synchronized copy in the `fall` cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on `fall` cycles, except the watchdog abort.
- IDLE: if sampled data is 0, go to DATA and clear `bit_cnt`. If sampled data is 1, stay in IDLE; this is treated as a glitch with no error strobe.
- DATA: `shreg <= {bit, shreg[7:1]}` (LSB first). `bit_cnt` counts 0..7. After the 8th bit, go to PARITY.
- PARITY: capture the parity bit into a holding flop, then go to STOP.
- STOP, sampled 1: `rx_data <= shreg`, `rx_parity <= held parity`, pulse `rx_valid`, go to IDLE.
- STOP, sampled 0: pulse `rx_frame_err`, leave `rx_data`/`rx_parity` unchanged, go to IDLE.
- The block performs no parity judgement. That is the downstream stage's job.
- `rx_valid`, `rx_frame_err` and `rx_timeout` are mutually exclusive. Each is high for exactly one cycle per event.

## Timing
- Reset values: `rx_data`=0x00, `rx_parity`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_timeout`=0, `rx_busy`=0, state IDLE, `bit_cnt`=0, watchdog count 0.
- Latency: a pin falling edge settles into the last sync flop after `SYNC_STAGES` clk edges. `fall` is high in the following cycle. The registered strobe and data become visible after the next edge, i.e. `SYNC_STAGES+1` edges after pin capture. With the default, `rx_valid` is high 3 cycles after the 11th falling edge is first captured.
- All outputs are registered. No combinational path runs from the PS/2 pins to the outputs.
- Back-to-back frames are accepted. IDLE can take a start bit on the first `fall` after a STOP.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded.
- Minimum PS/2 clock low/high time must exceed `SYNC_STAGES+1` system clocks. For a 10-16.7 kHz PS/2 clock this holds at any clk ≥ 1 MHz.

## Configuration
- Macro: `PS2_RX_TIMEOUT_EN`.
- Defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES)` clears on every `fall` and while in IDLE, and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES-1` in a non-IDLE state: pulse `rx_timeout`, go to IDLE, clear the counter, leave `rx_data` unchanged.
  - A `fall` in the same cycle as the terminal count takes precedence: it is processed normally and no timeout fires.
- Undefined: no counter logic; `rx_timeout` is tied to 0. A stalled frame waits indefinitely, and `rx_busy` stays high.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum `ps2_rx_state_t` (IDLE, DATA, PARITY, STOP);
  - `PS2_DATA_BITS`=8 and `PS2_FRAME_BITS`=11;
  - default `PS2_TIMEOUT_CYCLES`=5000.
- Sub-module `ps2_sync_edge`: N-stage synchronizer for clk and data plus falling-edge detect. It outputs `clk_fall` and `data_sync`, and is reusable by the future host-to-device transmitter.

## Test plan
- Frame 0x1C, parity 0, stop 1, at 12.5 kHz: one `rx_valid` pulse, `rx_data`=0x1C, `rx_parity`=0, no other strobes.
- Good frame 0xE0, then a frame 0x75 with stop bit 0: `rx_valid` with 0xE0, then `rx_frame_err`. `rx_data` stays 0xE0, `rx_parity` unchanged.
- Falling edge with `ps2_data`=1 while in IDLE: no strobes, `rx_busy` stays 0. A following good frame 0x5A is received correctly.
- With `PS2_RX_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: stop `ps2_clk` after the 5th falling edge. `rx_timeout` pulses exactly 100 cycles after the last `fall`, then `rx_busy`=0. A next frame 0xF0 gives `rx_valid` with 0xF0.
- Assert `rst_n` low after 6 bits of a frame: all outputs return to reset values asynchronously. After release, frame 0x12 is received correctly, with no spurious edge at release.
- Two back-to-back frames 0xE0 and 0x75 with minimal inter-frame gap: exactly two `rx_valid` pulses, carrying 0xE0 then 0x75.
